// File: rtl/smj_hand_collector.sv
// Collects tiles from a valid/ready stream into a 5-tile hand and holds it for the evaluator.
// Optional build macro SMJ_GAP_TIMEOUT_EN discards a partial hand after TIMEOUT_CYC idle cycles.
module smj_hand_collector #(
    parameter int TILE_W      = 6,
    parameter int HAND_SZ     = 5,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [TILE_W-1:0] in_tile,
    output logic              in_ready,
    output logic              hand_valid,
    input  logic              hand_ready,
    output logic [TILE_W-1:0] hand_n0,
    output logic [TILE_W-1:0] hand_n1,
    output logic [TILE_W-1:0] hand_n2,
    output logic [TILE_W-1:0] hand_n3,
    output logic [TILE_W-1:0] hand_n4,
    output logic [CNT_W-1:0]  hand_cnt,
    output logic              timeout_err,
    output logic              o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready and hand_valid are registered state decodes, so no input reaches them combinationally.
    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(HAND_SZ - 1);

    state_t            r_state;
    logic [2:0]        r_idx;
    logic [TILE_W-1:0] r_slot [HAND_SZ];
    logic              r_in_ready;
    logic              r_hand_valid;
    logic [CNT_W-1:0]  r_hand_cnt;
    logic              w_accept;

    assign w_accept = in_valid && r_in_ready;

`ifdef SMJ_GAP_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic [IDLE_W-1:0] r_idle;
    logic              r_timeout_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_COLLECT;
            r_idx        <= 3'd0;
            r_in_ready   <= 1'b0;
            r_hand_valid <= 1'b0;
            r_hand_cnt   <= '0;
            for (int i = 0; i < HAND_SZ; i++) begin
                r_slot[i] <= '0;
            end
`ifdef SMJ_GAP_TIMEOUT_EN
            r_idle        <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
`ifdef SMJ_GAP_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                S_COLLECT: begin
                    if (w_accept) begin
                        r_slot[r_idx] <= in_tile;
`ifdef SMJ_GAP_TIMEOUT_EN
                        r_idle <= '0;
`endif
                        if (r_idx == LAST_IDX) begin
                            r_idx        <= 3'd0;
                            r_state      <= S_HOLD;
                            r_hand_valid <= 1'b1;
                            r_in_ready   <= 1'b0;
                        end else begin
                            r_idx      <= r_idx + 3'd1;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
`ifdef SMJ_GAP_TIMEOUT_EN
                        // Idle edges only count once a hand has started; expiry drops the partial hand.
                        if (r_idx == 3'd0) begin
                            r_idle <= '0;
                        end else if (r_idle == IDLE_LAST) begin
                            r_idx         <= 3'd0;
                            r_idle        <= '0;
                            r_timeout_err <= 1'b1;
                        end else begin
                            r_idle <= r_idle + 1'b1;
                        end
`endif
                    end
                end
                S_HOLD: begin
`ifdef SMJ_GAP_TIMEOUT_EN
                    r_idle <= '0;
`endif
                    if (hand_ready) begin
                        r_state      <= S_COLLECT;
                        r_hand_valid <= 1'b0;
                        r_in_ready   <= 1'b1;
                        r_hand_cnt   <= r_hand_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_COLLECT;
                    r_idx        <= 3'd0;
                    r_hand_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign hand_valid  = r_hand_valid;
    assign hand_cnt    = r_hand_cnt;
    assign o_dbg_state = r_state;
    assign hand_n0     = r_slot[0];
    assign hand_n1     = r_slot[1];
    assign hand_n2     = r_slot[2];
    assign hand_n3     = r_slot[3];
    assign hand_n4     = r_slot[4];

`ifdef SMJ_GAP_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_smj_hand_collector.sv
// Randomized scoreboard bench for smj_hand_collector: a queue-based model predicts every cycle
// and a negedge monitor checks each handed-off hand against the expected-hand queue.
module tb_smj_hand_collector;

    localparam int TW     = 6;
    localparam int TO_CYC = 16;
`ifdef SMJ_GAP_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [TW-1:0] in_tile;
    logic          in_ready;
    logic          hand_valid;
    logic          hand_ready;
    logic [TW-1:0] hand_n0, hand_n1, hand_n2, hand_n3, hand_n4;
    logic [7:0]    hand_cnt;
    logic          timeout_err;
    logic          o_dbg_state;

    smj_hand_collector #(
        .TILE_W(TW), .HAND_SZ(5), .CNT_W(8), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_tile(in_tile), .in_ready(in_ready),
        .hand_valid(hand_valid), .hand_ready(hand_ready),
        .hand_n0(hand_n0), .hand_n1(hand_n1), .hand_n2(hand_n2),
        .hand_n3(hand_n3), .hand_n4(hand_n4),
        .hand_cnt(hand_cnt), .timeout_err(timeout_err), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: partial hand as a tile queue, pending hands as packed words.
    logic [TW-1:0]   m_parts[$];
    logic [5*TW-1:0] exp_q[$];
    bit              m_hold;
    bit              m_ready;
    bit              m_to;
    int              m_idle;
    logic [7:0]      m_cnt;
    int              m_total;
    int              pulse_cnt;
    int              tests;
    int              fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5*TW-1:0] cur_hand();
        return {hand_n0, hand_n1, hand_n2, hand_n3, hand_n4};
    endfunction

    task automatic model_reset();
        m_parts.delete();
        exp_q.delete();
        m_hold  = 1'b0;
        m_ready = 1'b0;
        m_to    = 1'b0;
        m_idle  = 0;
        m_cnt   = 8'd0;
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input bit v, input logic [TW-1:0] t, input bit hr);
        bit acc;
        in_valid   = v;
        in_tile    = t;
        hand_ready = hr;
        @(posedge clk);
        acc  = v && m_ready;
        m_to = 1'b0;
        if (m_hold) begin
            if (hr) begin
                m_hold = 1'b0;
                m_cnt++;
                m_total++;
            end
        end else if (acc) begin
            m_parts.push_back(t);
            m_idle = 0;
            if (m_parts.size() == 5) begin
                exp_q.push_back({m_parts[0], m_parts[1], m_parts[2], m_parts[3], m_parts[4]});
                m_parts.delete();
                m_hold = 1'b1;
            end
        end else if (TO_EN && m_parts.size() != 0) begin
            m_idle++;
            if (m_idle == TO_CYC) begin
                m_parts.delete();
                m_idle = 0;
                m_to   = 1'b1;
            end
        end
        m_ready = !m_hold;
        #1;
        check("in_ready", in_ready, m_ready);
        check("hand_valid", hand_valid, m_hold);
        check("hand_cnt", hand_cnt, m_cnt);
        check("timeout_err", timeout_err, m_to);
        check("dbg_state", o_dbg_state, m_hold);
        if (timeout_err === 1'b1) pulse_cnt++;
    endtask

    // Asserts reset in the middle of a cycle and checks outputs clear without waiting for an edge.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_hand_valid", hand_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_hand_cnt", hand_cnt, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_hand", cur_hand(), 0);
        model_reset();
        in_valid   = 1'b0;
        hand_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && hand_valid === 1'b1 && hand_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL hand_unexpected: got 0x%0h expected none", cur_hand());
            end else begin
                check("hand", cur_hand(), exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [TW-1:0] s1_tiles [5];
        int guard;
        tests = 0; fails = 0; m_total = 0; pulse_cnt = 0;
        s1_tiles = '{6'h11, 6'h12, 6'h13, 6'h25, 6'h25};
        rst_n = 1'b0; in_valid = 1'b0; in_tile = '0; hand_ready = 1'b0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("por_hand_valid", hand_valid, 0);
        check("por_in_ready", in_ready, 0);
        check("por_hand", cur_hand(), 0);
        check("por_hand_cnt", hand_cnt, 0);
        step(1'b0, '0, 1'b0);

        // Fixed hand, then a long stall with an illegal tile offered.
        foreach (s1_tiles[i]) step(1'b1, s1_tiles[i], 1'b0);
        check("s1_hand", cur_hand(), {6'h11, 6'h12, 6'h13, 6'h25, 6'h25});
        repeat (10) step(1'b1, 6'h3F, 1'b0);
        check("s2_hand_stable", cur_hand(), {6'h11, 6'h12, 6'h13, 6'h25, 6'h25});
        step(1'b0, '0, 1'b1);
        check("s2_cnt_one", hand_cnt, 1);
        check("s2_valid_low", hand_valid, 0);

        // Reset with a partial hand in flight.
        repeat (3) step(1'b1, TW'($urandom_range(0, 63)), 1'b0);
        mid_reset();
        step(1'b0, '0, 1'b0);
        for (int i = 1; i <= 5; i++) step(1'b1, TW'(i), 1'b0);
        check("s3_hand", cur_hand(), {6'h01, 6'h02, 6'h03, 6'h04, 6'h05});
        step(1'b0, '0, 1'b1);

        // Random gaps and random backpressure.
        repeat (300) step($urandom_range(0, 3) != 0, TW'($urandom_range(0, 63)), $urandom_range(0, 1) == 1);

        // 300 back-to-back hands from a clean counter.
        mid_reset();
        m_total = 0;
        guard = 0;
        while (m_total < 300 && guard < 4000) begin
            step(1'b1, TW'($urandom_range(0, 63)), 1'b1);
            guard++;
        end
        check("s4_hands_done", m_total, 300);
        check("s4_cnt_wrap", hand_cnt, 44);

        // Idle gap of TIMEOUT_CYC cycles inside a hand.
        step(1'b0, '0, 1'b1);
        pulse_cnt = 0;
        step(1'b1, 6'h21, 1'b0);
        step(1'b1, 6'h22, 1'b0);
        repeat (TO_CYC) step(1'b0, '0, 1'b0);
        for (int i = 1; i <= 5; i++) step(1'b1, TW'(6'h30 + i), 1'b0);
        check("s5_pulses", pulse_cnt, TO_EN ? 1 : 0);
        check("s5_hand", cur_hand(), TO_EN ? {6'h31, 6'h32, 6'h33, 6'h34, 6'h35}
                                           : {6'h21, 6'h22, 6'h31, 6'h32, 6'h33});
        step(1'b0, '0, 1'b1);

        // Accept landing on what would be the expiry edge.
        pulse_cnt = 0;
        step(1'b1, 6'h01, 1'b0);
        step(1'b1, 6'h02, 1'b0);
        repeat (TO_CYC - 1) step(1'b0, '0, 1'b0);
        for (int i = 3; i <= 5; i++) step(1'b1, TW'(i), 1'b0);
        check("s5_no_pulse", pulse_cnt, 0);
        check("s5_hand2", cur_hand(), {6'h01, 6'h02, 6'h03, 6'h04, 6'h05});
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        check("pending_left", exp_q.size(), m_hold ? 1 : 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/smj_hand_collector.md
Name: smj_hand_collector

Overview:
Upstream feeder for the combinational hand evaluator (sort + win/invalid classification).
- Accepts tiles one per cycle over a valid/ready stream.
- Assembles them into a 5-tile hand, in arrival order.
- Presents the hand as five parallel 6-bit buses with a valid/ready handshake; the evaluator's 2-bit result is captured downstream of this block.

Parameters:
TILE_W, 6, tile code width ([5:4] suit, 00 = honor; [3:0] rank)
HAND_SZ, 5, tiles per hand; the evaluator interface is fixed at 5
CNT_W, 8, width of the completed-hand counter
TIMEOUT_CYC, 16, maximum idle gap between tiles of one hand (optional feature only)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  tile present on in_tile
in_tile  in  TILE_W  tile code; passed through unchecked
in_ready  out  1  collector can accept a tile this cycle
hand_valid  out  1  hand_n0..hand_n4 hold a complete hand
hand_ready  in  1  evaluator side consumes the hand
hand_n0..hand_n4  out  TILE_W each  tiles in arrival order (n0 = first)
hand_cnt  out  CNT_W  number of hands handed off since reset
timeout_err  out  1  one-cycle pulse: partial hand discarded (optional feature only; tied 0 otherwise)

Behaviour:
Reset (async assert, sync release):
- state = COLLECT, tile index = 0, all hand_n* = 0, hand_valid = 0, hand_cnt = 0, timeout_err = 0.
- in_ready = 1 after the first clock edge following release.

Accept rule:
- A tile is accepted on a rising edge where in_valid && in_ready.
- No acceptance when in_ready = 0; in_tile is ignored in that case.

States:
- COLLECT:
  - in_ready = 1, hand_valid = 0.
  - Each accepted tile is written to slot[idx], then idx increments.
  - When the 5th tile (idx = 4) is accepted: go to HOLD next cycle and reset idx to 0.
- HOLD:
  - in_ready = 0, hand_valid = 1.
  - hand_n* stay stable until consumed; no combinational path from in_* to hand_*.
  - On hand_valid && hand_ready: return to COLLECT next cycle and increment hand_cnt.
  - hand_cnt wraps modulo 2^CNT_W.

Latency and throughput:
- hand_valid rises on the edge that accepts the 5th tile, so it is visible the following cycle.
- Minimum spacing is 6 cycles per hand (5 accepts + 1 handoff).
- in_ready is a registered state decode. No bypass is allowed: a tile offered in the same cycle as the handoff is not accepted.

Other rules:
- hand_ready while in COLLECT: ignored.
- Slot registers keep the previous hand's values until overwritten; only hand_valid qualifies them.
- Reset mid-hand or mid-HOLD: partial and pending hands are lost; no hand_valid glitch.
- in_valid held high continuously: accepts 5 tiles in 5 consecutive cycles, then stalls in HOLD.

Optional Feature:
Macro: SMJ_GAP_TIMEOUT_EN
- Defined:
  - An idle counter runs in COLLECT while idx != 0 and no tile is accepted; any accept clears it.
  - When the counter reaches TIMEOUT_CYC, on that edge: idx returns to 0, the counter clears, and timeout_err pulses high for exactly 1 cycle.
  - State stays COLLECT; hand_cnt is unchanged.
  - If an accept coincides with the expiry edge, the accept wins and no timeout occurs.
  - The counter is held at 0 in HOLD and while idx = 0.
- Undefined: no counter logic; timeout_err is constant 0; partial hands wait indefinitely.

Test Plan:
1. Post-reset check -> all outputs 0, in_ready=1; then feed 0x11,0x12,0x13,0x25,0x25 back-to-back with hand_ready=0 -> hand_valid=1 the cycle after the 5th accept; hand_n0..4 = 0x11,0x12,0x13,0x25,0x25; in_ready=0.
2. Hold hand_ready low 10 cycles while in_valid=1 with 0x3F on in_tile -> hand_n* unchanged and no tile accepted; then hand_ready=1 for one cycle -> hand_valid=0 next cycle, hand_cnt=1, in_ready=1.
3. Feed 3 tiles, assert rst_n=0 mid-cycle -> outputs clear immediately; after release, feed 5 tiles 0x01..0x05 -> hand_n0..4 = 0x01..0x05 (no stale tiles).
4. Gapped input: 5 tiles with 0-3 random idle cycles between them, TIMEOUT_CYC large -> hand_valid after the 5th accept only; 300 hands back-to-back with hand_ready=1 -> hand_cnt wraps to 44 (300 mod 256).
5. SMJ_GAP_TIMEOUT_EN, TIMEOUT_CYC=16: feed 2 tiles, idle 16 cycles -> timeout_err single pulse; next 5 tiles 0x31..0x35 form the hand exactly; an accept on the expiry cycle -> no pulse.
6. Without the macro: same stimulus as scenario 5 -> timeout_err stays 0; the 2 stale tiles become hand_n0/hand_n1 of the next hand.
